// File: rtl/regfile_pkg.sv
// regfile_pkg: constants and shared types for the register-file writeback path.
//   RF_DATA_W / RF_ADDR_W / RF_NREG : default data width, index width, register count
//   REG_ZERO                        : hardwired-zero register index
//   REQ_ALU / REQ_MC                : requester ids (single-cycle ALU, multi-cycle unit)
//   wb_req_t                        : writeback request {valid, addr, data} at default widths
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_NREG   = 32;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MC  = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wbarb_scoreboard.sv
// wbarb_scoreboard: busy bits for destinations owned by in-flight multi-cycle ops.
//   clk, reset         : clock, asynchronous active-high reset (clears all busy bits)
//   i_set_en/i_set_addr: issue of a multi-cycle op; marks its destination busy
//   i_clr_en/i_clr_addr: multi-cycle result committing this edge; frees the destination
//   i_rs1/i_rs2        : decode source indices
//   o_hz1/o_hz2        : source pending on a multi-cycle result (combinational)
// Register 0 has no busy bit, so it never reports a hazard.
module wbarb_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  output logic              o_hz1,
  output logic              o_hz2
);

  logic [NREG-1:1] r_busy;
  logic [NREG-1:1] w_busy_nxt;

  // Clear is applied first so a same-edge set of the same register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 1; i < NREG; i++) begin
      if (i_clr_en && i_clr_addr == ADDR_W'(i)) w_busy_nxt[i] = 1'b0;
      if (i_set_en && i_set_addr == ADDR_W'(i)) w_busy_nxt[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_nxt;
  end

  always_comb begin
    o_hz1 = 1'b0;
    o_hz2 = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (i_rs1 == ADDR_W'(i)) o_hz1 = r_busy[i];
      if (i_rs2 == ADDR_W'(i)) o_hz2 = r_busy[i];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register-file write port between
// the ALU (requester 0) and the multi-cycle unit (requester 1), with a one-cycle
// registered output stage and an optional busy-register scoreboard.
//   clk, reset                    : clock, asynchronous active-high reset
//   i_wb0_valid/addr/data, o_wb0_ready : ALU writeback request / accept
//   i_wb1_valid/addr/data, o_wb1_ready : multi-cycle writeback request / accept
//   i_iss_valid, i_iss_rd         : multi-cycle op issued, its destination
//   i_rs1, i_rs2, o_hz1, o_hz2    : decode sources and their pending flags
//   o_rf_we, o_rf_waddr, o_rf_wdata : register file write port
// Build option WBARB_SCOREBOARD_EN: when defined the scoreboard drives o_hz1/o_hz2;
// otherwise the issue/source inputs are ignored and the hazard outputs are 0.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NREG   = RF_NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wb0_valid,
  input  logic [ADDR_W-1:0] i_wb0_addr,
  input  logic [DATA_W-1:0] i_wb0_data,
  output logic              o_wb0_ready,
  input  logic              i_wb1_valid,
  input  logic [ADDR_W-1:0] i_wb1_addr,
  input  logic [DATA_W-1:0] i_wb1_data,
  output logic              o_wb1_ready,
  input  logic              i_iss_valid,
  input  logic [ADDR_W-1:0] i_iss_rd,
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  output logic              o_hz1,
  output logic              o_hz2,
  output logic              o_rf_we,
  output logic [ADDR_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata
);

  logic              r_last;   // requester granted on the most recent transfer
  logic              r_we;
  logic              r_src;    // requester that produced the staged write
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic              w_sel;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_nz;

  // On a tie the requester that did not win last time goes first.
  assign w_gnt0 = i_wb0_valid && (!i_wb1_valid || r_last == REQ_MC);
  assign w_gnt1 = i_wb1_valid && (!i_wb0_valid || r_last == REQ_ALU);

  // Ready is masked during reset so nothing is considered accepted.
  assign o_wb0_ready = w_gnt0 && !reset;
  assign o_wb1_ready = w_gnt1 && !reset;

  assign w_xfer = w_gnt0 || w_gnt1;
  assign w_sel  = w_gnt1 ? REQ_MC : REQ_ALU;
  assign w_addr = w_gnt1 ? i_wb1_addr : i_wb0_addr;
  assign w_data = w_gnt1 ? i_wb1_data : i_wb0_data;
  assign w_nz   = (w_addr != REG_ZERO);

  // An accepted x0 write still consumes its grant but stages a zeroed, disabled write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last  <= REQ_MC;
      r_we    <= 1'b0;
      r_src   <= REQ_ALU;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_xfer) begin
      r_last  <= w_sel;
      r_we    <= w_nz;
      r_src   <= w_sel;
      r_waddr <= w_nz ? w_addr : '0;
      r_wdata <= w_nz ? w_data : '0;
    end else begin
      r_we    <= 1'b0;
    end
  end

  assign o_rf_we    = r_we;
  assign o_rf_waddr = r_waddr;
  assign o_rf_wdata = r_wdata;

`ifdef WBARB_SCOREBOARD_EN
  // Busy clears on the edge the staged multi-cycle result commits.
  logic w_clr_en;
  assign w_clr_en = r_we && (r_src == REQ_MC);

  wbarb_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREG   (NREG)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (i_iss_valid),
    .i_set_addr (i_iss_rd),
    .i_clr_en   (w_clr_en),
    .i_clr_addr (r_waddr),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_hz1      (o_hz1),
    .o_hz2      (o_hz2)
  );
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{i_iss_valid, i_iss_rd, i_rs1, i_rs2};
  assign o_hz1 = 1'b0;
  assign o_hz2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

`ifdef WBARB_SCOREBOARD_EN
  localparam bit SB_EN = 1'b1;
`else
  localparam bit SB_EN = 1'b0;
`endif

  logic                 clk;
  logic                 reset;
  wb_req_t              req0, req1;
  logic                 wb0_ready, wb1_ready;
  logic                 iss_valid;
  logic [RF_ADDR_W-1:0] iss_rd, rs1, rs2;
  logic                 hz1, hz2;
  logic                 rf_we;
  logic [RF_ADDR_W-1:0] rf_waddr;
  logic [RF_DATA_W-1:0] rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .i_wb0_valid (req0.valid),
    .i_wb0_addr  (req0.addr),
    .i_wb0_data  (req0.data),
    .o_wb0_ready (wb0_ready),
    .i_wb1_valid (req1.valid),
    .i_wb1_addr  (req1.addr),
    .i_wb1_data  (req1.data),
    .o_wb1_ready (wb1_ready),
    .i_iss_valid (iss_valid),
    .i_iss_rd    (iss_rd),
    .i_rs1       (rs1),
    .i_rs2       (rs2),
    .o_hz1       (hz1),
    .o_hz2       (hz2),
    .o_rf_we     (rf_we),
    .o_rf_waddr  (rf_waddr),
    .o_rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0 = '0; req1 = '0;
    iss_valid = 1'b0; iss_rd = '0; rs1 = '0; rs2 = '0;
    #12;
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", rf_we); end
    n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_addr_data got %h/%h want 0/0", rf_waddr, rf_wdata); end
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_first_tie();
    req0 = '{1'b1, 5'd3, 32'hAAAA0001};
    req1 = '{1'b1, 5'd4, 32'hBBBB0002};
    #1;
    n_checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin n_fail++; $display("FAIL tie_ready got %b want 10", {wb0_ready, wb1_ready}); end
    step();
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hAAAA0001}) begin n_fail++; $display("FAIL tie_out0 got %b/%0d/%h want 1/3/aaaa0001", rf_we, rf_waddr, rf_wdata); end
    req0.valid = 1'b0;
    #1;
    n_checks++; if ({wb0_ready, wb1_ready} !== 2'b01) begin n_fail++; $display("FAIL tie_ready1 got %b want 01", {wb0_ready, wb1_ready}); end
    step();
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hBBBB0002}) begin n_fail++; $display("FAIL tie_out1 got %b/%0d/%h want 1/4/bbbb0002", rf_we, rf_waddr, rf_wdata); end
    req1.valid = 1'b0;
  endtask

  task automatic test_contention();
    req0 = '{1'b1, 5'd10, 32'h0000_0A0A};
    req1 = '{1'b1, 5'd11, 32'h0000_0B0B};
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++; if (wb0_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", i, wb0_ready, (i % 2 == 0)); end
      step();
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== ((i % 2 == 0) ? 5'd10 : 5'd11)) begin n_fail++; $display("FAIL rr_out[%0d] got %b/%0d want 1/%0d", i, rf_we, rf_waddr, (i % 2 == 0) ? 10 : 11); end
    end
    req0.valid = 1'b0; req1.valid = 1'b0;
    step();
    n_checks++; if ({rf_we, rf_waddr} !== {1'b0, 5'd11}) begin n_fail++; $display("FAIL idle_hold got %b/%0d want 0/11", rf_we, rf_waddr); end
  endtask

  task automatic test_x0_write();
    req0 = '{1'b1, 5'd0, 32'hFFFF_FFFF};
    #1;
    n_checks++; if (wb0_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", wb0_ready); end
    step();
    req0.valid = 1'b0;
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin n_fail++; $display("FAIL x0_out got %b/%0d/%h want 0/0/0", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_hazard_clear();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
    #1;
    n_checks++; if (hz1 !== SB_EN) begin n_fail++; $display("FAIL hz_set got %b want %b", hz1, SB_EN); end
    n_checks++; if (hz2 !== 1'b0) begin n_fail++; $display("FAIL hz_x0 got %b want 0", hz2); end
    req0 = '{1'b1, 5'd7, 32'h1111_0007};
    step();
    req0.valid = 1'b0;
    step();
    n_checks++; if (hz1 !== SB_EN) begin n_fail++; $display("FAIL hz_alu_noclr got %b want %b", hz1, SB_EN); end
    req1 = '{1'b1, 5'd7, 32'h7777_0007};
    step();
    req1.valid = 1'b0;
    n_checks++; if ({rf_we, rf_waddr, hz1} !== {1'b1, 5'd7, SB_EN}) begin n_fail++; $display("FAIL hz_staged got %b/%0d/%b want 1/7/%b", rf_we, rf_waddr, hz1, SB_EN); end
    step();
    n_checks++; if (hz1 !== 1'b0) begin n_fail++; $display("FAIL hz_cleared got %b want 0", hz1); end
  endtask

  task automatic test_same_edge();
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    req1 = '{1'b1, 5'd9, 32'h9999_0009};
    step();
    req1.valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0; rs1 = 5'd9;
    #1;
    n_checks++; if (hz1 !== SB_EN) begin n_fail++; $display("FAIL same_edge got %b want %b", hz1, SB_EN); end
    step();
    n_checks++; if (hz1 !== SB_EN) begin n_fail++; $display("FAIL same_edge_hold got %b want %b", hz1, SB_EN); end
  endtask

  task automatic test_reset_mid_op();
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    iss_valid = 1'b0;
    req0 = '{1'b1, 5'd12, 32'hCCCC_000C};
    step();
    req0.valid = 1'b0; rs2 = 5'd5;
    #1;
    n_checks++; if ({rf_we, hz2} !== {1'b1, SB_EN}) begin n_fail++; $display("FAIL pre_reset got %b/%b want 1/%b", rf_we, hz2, SB_EN); end
    reset = 1'b1;
    #1;
    n_checks++; if ({rf_we, rf_waddr, hz2, hz1} !== {1'b0, 5'd0, 1'b0, 1'b0}) begin n_fail++; $display("FAIL mid_reset got %b/%0d/%b/%b want 0/0/0/0", rf_we, rf_waddr, hz2, hz1); end
    req0 = '{1'b1, 5'd1, 32'h0000_0001};
    req1 = '{1'b1, 5'd2, 32'h0000_0002};
    #1;
    n_checks++; if ({wb0_ready, wb1_ready} !== 2'b00) begin n_fail++; $display("FAIL ready_in_reset got %b want 00", {wb0_ready, wb1_ready}); end
    reset = 1'b0;
    #1;
    n_checks++; if ({wb0_ready, wb1_ready} !== 2'b10) begin n_fail++; $display("FAIL post_reset_tie got %b want 10", {wb0_ready, wb1_ready}); end
    step();
    req0.valid = 1'b0;
    n_checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd1, 32'd1}) begin n_fail++; $display("FAIL post_reset_out got %b/%0d/%h want 1/1/1", rf_we, rf_waddr, rf_wdata); end
    req1.valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_tie();
    test_contention();
    test_x0_write();
    test_hazard_clear();
    test_same_edge();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources.
- Requester 0: the single-cycle ALU path.
- Requester 1: the multi-cycle unit (load/store or mul/div).

The block uses round-robin arbitration and registers the winning write for one cycle before it drives the register file. A scoreboard tracks destination registers owned by in-flight multi-cycle operations and raises read-hazard flags for the decode/stall logic. It sits between the execute stages and the register file write inputs.

Parameters:
DATA_W, 32, width of writeback data
ADDR_W, 5, register index width
NREG, 32, number of architectural registers (index 0 hardwired zero)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wb0_valid  in  1  ALU writeback request
wb0_addr  in  ADDR_W  ALU destination register
wb0_data  in  DATA_W  ALU result
wb0_ready  out  1  ALU request accepted this cycle
wb1_valid  in  1  multi-cycle unit writeback request
wb1_addr  in  ADDR_W  multi-cycle destination register
wb1_data  in  DATA_W  multi-cycle result
wb1_ready  out  1  multi-cycle request accepted this cycle
iss_valid  in  1  multi-cycle operation issued this cycle
iss_rd  in  ADDR_W  destination of the issued operation
rs1  in  ADDR_W  decode source register 1
rs2  in  ADDR_W  decode source register 2
hz1  out  1  rs1 pending on multi-cycle result
hz2  out  1  rs2 pending on multi-cycle result
rf_we  out  1  register file write enable
rf_waddr  out  ADDR_W  register file write index
rf_wdata  out  DATA_W  register file write data

Behaviour:
- Reset (asynchronous, active-high): clock is clk.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - All scoreboard busy bits are cleared. last_grant=1, so requester 0 wins the first tie.
  - wb0_ready and wb1_ready are 0 while reset is asserted.
  - Reset mid-operation drops any staged write and all busy bits; no write reaches the register file.
- Handshake: a transfer occurs on the clock edge where valid&&ready. Ready is combinational from the valids and last_grant. There is no combinational path from ready to valid.
- Arbitration:
  - Exactly one requester is granted per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant wins.
  - last_grant updates only on a transfer.
  - The loser holds valid, addr and data stable until accepted.
- Output stage: latency is exactly 1 cycle. The edge that accepts a request loads rf_waddr/rf_wdata and sets rf_we=1. The register file commits on the following edge.
- Idle cycles: with no transfer, rf_we=0 the next cycle and addr/data hold their previous values.
- x0 writes: an accepted request with addr==0 consumes its grant. It produces rf_we=0 and loads rf_waddr=0, rf_wdata=0.
- Scoreboard busy[NREG-1:1]:
  - Set: iss_valid with iss_rd!=0 sets busy[iss_rd] at the edge.
  - Clear: busy[a] clears at the edge where the output stage holds a requester-1 write to a (rf_we=1, src=1, rf_waddr=a), i.e. when the data commits. An internal src bit is kept with the staged write.
  - Same-edge set and clear of the same register: set wins.
  - iss_rd==0 is ignored.
  - A requester-0 write to a busy register does not clear it.
- Hazards: hz1=busy[rs1] and hz2=busy[rs2], combinational. Both are 0 for index 0.
- Writeback ordering between the two sources is the issue logic's responsibility. The arbiter does not reorder or check WAW.

Optional Feature:
Macro WBARB_SCOREBOARD_EN.
- Defined: the scoreboard and hazard logic are as above.
- Undefined: the busy register, iss_* and rs* logic are removed; hz1 and hz2 are tied to 0; iss_valid, iss_rd, rs1 and rs2 are ignored. The port list is unchanged.

Decomposition:
- Shared package (regfile_pkg):
  - DATA_W, ADDR_W and NREG constants.
  - Zero-register index constant.
  - Requester-id encoding (REQ_ALU=0, REQ_MC=1).
  - Typedef for the writeback request struct {valid, addr, data}.
- One natural sub-module, wbarb_scoreboard: busy vector, set/clear priority and hazard lookup. It is instantiated under WBARB_SCOREBOARD_EN.

Test Plan:
1. Both valid from reset, wb0 (addr 3, 0xAAAA0001) and wb1 (addr 4, 0xBBBB0002):
   - cycle 1: wb0_ready=1, wb1_ready=0; rf_we=1, waddr=3 next cycle.
   - cycle 2: wb1 granted; waddr=4, wdata=0xBBBB0002.
2. Continuous contention over 6 cycles -> grants alternate 0,1,0,1,0,1 with no idle rf_we gap.
3. wb0 writes addr 0 with 0xFFFFFFFF -> wb0_ready=1; next cycle rf_we=0, rf_waddr=0.
4. iss_valid with iss_rd=7, then rs1=7:
   - hz1=1 until wb1 writes 7 and rf_we has been high for addr 7 one cycle.
   - then hz1=0; wb0 write to 7 meanwhile leaves hz1=1.
5. Same edge: iss_rd=9 issued while the staged wb1 write to 9 commits -> busy[9] stays 1.
6. Assert reset while rf_we=1 and busy[5]=1 -> rf_we=0 immediately; hz for 5 = 0; first post-reset tie is granted to wb0.
